// File: rtl/maxpool2x2_stream_pkg.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream_pkg
// Shared CNN definitions for the pooling stages:
//   - DATA_WIDTH        default feature width
//   - MNIST_* constants feature-map sizes along the MNIST pipeline (24,12,8,4)
//   - row/column phase enums used by the 2x2 pooling stages
//   - smax()            signed max on a SMAX_W-bit container; callers
//                       sign-extend their operands into it and truncate back
// No ports (package).
// -----------------------------------------------------------------------------
package maxpool2x2_stream_pkg;

  localparam int DATA_WIDTH    = 8;

  localparam int MNIST_CONV1_W = 24;
  localparam int MNIST_POOL1_W = 12;
  localparam int MNIST_CONV2_W = 8;
  localparam int MNIST_POOL2_W = 4;

  // Widest feature width the shared max helper can handle.
  localparam int SMAX_W        = 32;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_phase_e;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } col_phase_e;

  // Signed maximum; on equal operands 'a' is returned (same value either way).
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    logic signed [SMAX_W-1:0] r;
    if (a >= b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_pool_row_buf.sv
// -----------------------------------------------------------------------------
// pool_row_buf
// Holds the horizontal pair maxima of the current even row so the following
// odd row can finish each 2x2 window. Plain register array with no reset:
// every entry is rewritten on an even row before the odd row reads it.
// Ports:
//   clk      clock (write on posedge)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (combinational read)
//   o_rdata  read data
// -----------------------------------------------------------------------------
module pool_row_buf
  import maxpool2x2_stream_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = MNIST_POOL1_W,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
// Streaming 2x2 / stride-2 signed max-pool. Pixels arrive in raster order, one
// per input_vld beat; one pooled value is emitted per completed window, in
// raster order of the pooled map. No backpressure.
// Optional build macro: MAXPOOL_RELU_EN -- clamps negative pooled results to 0.
// Ports:
//   clk         clock, all logic on posedge
//   rst         asynchronous active-low reset
//   input_vld   din valid this cycle
//   din         input pixel, signed WIDTH
//   output_vld  one-cycle pulse per pooled value
//   dout        pooled value, held between outputs
//   frame_done  pulse coincident with the last pooled output of a frame
// -----------------------------------------------------------------------------
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int IMG_W = MNIST_CONV1_W,
  parameter int IMG_H = MNIST_CONV1_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_vld,
  input  logic [WIDTH-1:0] din,
  output logic             output_vld,
  output logic [WIDTH-1:0] dout,
  output logic             frame_done
);

  // Column counter keeps at least 2 bits so the row-buffer address
  // (col_cnt >> 1) never collapses to zero width.
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = CW - 1;

  if (((IMG_W % 2) != 0) || ((IMG_H % 2) != 0)) begin : g_bad_dims
    $error("maxpool2x2_stream: IMG_W and IMG_H must both be even");
  end
  if (WIDTH > SMAX_W) begin : g_bad_width
    $error("maxpool2x2_stream: WIDTH exceeds shared max helper width");
  end

  // Signed max at this block's width via the shared helper.
  function automatic logic [WIDTH-1:0] max_w(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [SMAX_W-1:0] w_r;
    w_r = smax(SMAX_W'($signed(a)), SMAX_W'($signed(b)));
    return w_r[WIDTH-1:0];
  endfunction

  logic [CW-1:0]    r_col_cnt;
  logic [RW-1:0]    r_row_cnt;
  logic [WIDTH-1:0] r_h_max;
  logic [WIDTH-1:0] r_dout;
  logic             r_output_vld;
  logic             r_frame_done;

  logic [CW-1:0]    w_col_nxt;
  logic [RW-1:0]    w_row_nxt;
  logic             w_col_last;
  logic             w_row_last;
  row_phase_e       w_row_phase;
  col_phase_e       w_col_phase;
  logic [WIDTH-1:0] w_pair_max;
  logic [WIDTH-1:0] w_rb_rdata;
  logic [WIDTH-1:0] w_pool_max;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_rb_we;
  logic [AW-1:0]    w_rb_addr;

  assign w_row_phase = row_phase_e'(r_row_cnt[0]);
  assign w_col_phase = col_phase_e'(r_col_cnt[0]);
  assign w_rb_addr   = r_col_cnt[CW-1:1];

  // Raster position advance with wrap at row and frame end.
  always_comb begin
    w_col_last = (r_col_cnt == CW'(IMG_W - 1));
    w_row_last = (r_row_cnt == RW'(IMG_H - 1));
    w_col_nxt  = r_col_cnt;
    w_row_nxt  = r_row_cnt;
    if (w_col_last) begin
      w_col_nxt = {CW{1'b0}};
      if (w_row_last) begin
        w_row_nxt = {RW{1'b0}};
      end else begin
        w_row_nxt = r_row_cnt + RW'(1);
      end
    end else begin
      w_col_nxt = r_col_cnt + CW'(1);
    end
  end

  // Pair max of the current beat, then vertical max against the stored even-row pair.
  always_comb begin
    w_pair_max = max_w(r_h_max, din);
    w_pool_max = max_w(w_pair_max, w_rb_rdata);
    w_rb_we    = input_vld && (w_col_phase == SECOND) && (w_row_phase == EVEN_ROW);
  end

  // Output value shaping (optional ReLU); compare path is unaffected.
  always_comb begin
    w_dout_nxt = w_pool_max;
`ifdef MAXPOOL_RELU_EN
    if (w_pool_max[WIDTH-1]) begin
      w_dout_nxt = {WIDTH{1'b0}};
    end else begin
      w_dout_nxt = w_pool_max;
    end
`endif
  end

  pool_row_buf #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W / 2),
    .AW    (AW)
  ) u_row_buf (
    .clk     (clk),
    .i_we    (w_rb_we),
    .i_waddr (w_rb_addr),
    .i_wdata (w_pair_max),
    .i_raddr (w_rb_addr),
    .o_rdata (w_rb_rdata)
  );

  // Counters, horizontal holding register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt    <= {CW{1'b0}};
      r_row_cnt    <= {RW{1'b0}};
      r_h_max      <= {WIDTH{1'b0}};
      r_dout       <= {WIDTH{1'b0}};
      r_output_vld <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_output_vld <= 1'b0;
      r_frame_done <= 1'b0;
      if (input_vld) begin
        r_col_cnt <= w_col_nxt;
        r_row_cnt <= w_row_nxt;
        if (w_col_phase == FIRST) begin
          r_h_max <= din;
        end else if (w_row_phase == ODD_ROW) begin
          r_dout       <= w_dout_nxt;
          r_output_vld <= 1'b1;
          r_frame_done <= w_col_last && w_row_last;
        end
      end
    end
  end

  assign output_vld = r_output_vld;
  assign dout       = r_dout;
  assign frame_done = r_frame_done;

endmodule
